// File: rtl/fixed_point_divider_arbiter_pkg.sv
// Shared types for the divider arbiter: FSM states and the response bundle.
// Bundle widths follow the default divider (8-bit) and requester count (4).
package div_arb_pkg;

  localparam int DIV_W    = 8;
  localparam int NREQ_DEF = 4;
  localparam int ID_W     = $clog2(NREQ_DEF);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ABORT,
    RESP
  } state_t;

  typedef struct packed {
    logic [DIV_W-1:0] val;
    logic             dbz;
    logic             ovf;
    logic             tmo;
    logic [ID_W-1:0]  id;
  } rsp_t;

endpackage

// File: rtl/fixed_point_divider_arbiter_if.sv
// Requester/response bus of the divider arbiter.
// master: requesters + response sink; slave: the arbiter.
interface fixed_point_divider_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       i_req_valid;
  logic [NREQ-1:0]       o_req_ready;
  logic [NREQ*WIDTH-1:0] i_req_a;
  logic [NREQ*WIDTH-1:0] i_req_b;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [IDW-1:0]        o_rsp_id;
  logic [WIDTH-1:0]      o_rsp_val;
  logic                  o_rsp_dbz;
  logic                  o_rsp_ovf;
  logic                  o_rsp_tmo;

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_id,
    input  o_rsp_val, o_rsp_dbz, o_rsp_ovf, o_rsp_tmo
  );

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_id,
    output o_rsp_val, o_rsp_dbz, o_rsp_ovf, o_rsp_tmo
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first req at or after ptr, wrapping.
// Ports: req, ptr in; gnt (one-hot) and idx out.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Scan farthest-first so the nearest request is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/fixed_point_divider_arbiter.sv
// Shares one signed fixed-point divider among NREQ requesters.
// Ports: i_clk, i_rst_n, bus (request/response), o_div_*/i_div_* divider side.
module fixed_point_divider_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH   = DIV_W,
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  fixed_point_divider_arbiter_if.slave bus,
  output logic                 o_div_rst,
  output logic                 o_div_start,
  output logic [WIDTH-1:0]     o_div_a,
  output logic [WIDTH-1:0]     o_div_b,
  input  logic                 i_div_done,
  input  logic                 i_div_valid,
  input  logic                 i_div_dbz,
  input  logic                 i_div_ovf,
  input  logic [WIDTH-1:0]     i_div_val
);

  localparam int IDW  = $clog2(NREQ);
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  state_t          state_q;
  rsp_t            rsp_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  ptr_q;
  logic [WD_W-1:0] wdog_q;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  idx;
  logic            can_grant;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req (bus.i_req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (idx)
  );

  // The divider is still in reset for one cycle after i_rst_n rises.
  assign can_grant       = (state_q == IDLE) && !o_div_rst;
  assign bus.o_req_ready = can_grant ? gnt : '0;

  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_id    = rsp_q.id;
  assign bus.o_rsp_val   = rsp_q.val;
  assign bus.o_rsp_dbz   = rsp_q.dbz;
  assign bus.o_rsp_ovf   = rsp_q.ovf;
  assign bus.o_rsp_tmo   = rsp_q.tmo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      ptr_q       <= '0;
      wdog_q      <= '0;
      o_div_rst   <= 1'b1;
      o_div_start <= 1'b0;
      o_div_a     <= '0;
      o_div_b     <= '0;
    end else begin
      o_div_rst   <= 1'b0;
      o_div_start <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (can_grant && |bus.i_req_valid) begin
            o_div_a     <= bus.i_req_a[int'(idx) * WIDTH +: WIDTH];
            o_div_b     <= bus.i_req_b[int'(idx) * WIDTH +: WIDTH];
            rsp_q.id    <= idx;
            ptr_q       <= (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
            o_div_start <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          wdog_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (i_div_done) begin
            rsp_q.val   <= (i_div_dbz | i_div_ovf | ~i_div_valid)
                           ? '0 : i_div_val;
            rsp_q.dbz   <= i_div_dbz;
            rsp_q.ovf   <= i_div_ovf;
            rsp_q.tmo   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            o_div_rst <= 1'b1;
            state_q   <= ABORT;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        ABORT: begin
          rsp_q.val   <= '0;
          rsp_q.dbz   <= 1'b0;
          rsp_q.ovf   <= 1'b0;
          rsp_q.tmo   <= 1'b1;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_divider_arbiter.sv
// Randomized bench for fixed_point_divider_arbiter with a job-level model.
// A stub divider (Q4.4 signed) answers starts; a negedge monitor checks all.
module tb_fixed_point_divider_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TO = 64;

  typedef struct packed {
    logic [7:0] val;
    logic       dbz;
    logic       ovf;
    logic       tmo;
  } exp_t;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    bit         tmo;
  } job_t;

  logic clk;
  logic rst_n;
  logic div_rst, div_start, div_done, div_valid, div_dbz, div_ovf;
  logic [7:0] div_a, div_b, div_val;

  logic [N-1:0]      rvalid;
  logic [N-1:0][7:0] ra, rb;
  logic              rsp_ready;

  fixed_point_divider_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  assign bus.i_req_valid = rvalid;
  assign bus.i_req_a     = ra;
  assign bus.i_req_b     = rb;
  assign bus.i_rsp_ready = rsp_ready;

  fixed_point_divider_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus.slave),
    .o_div_rst   (div_rst),
    .o_div_start (div_start),
    .o_div_a     (div_a),
    .o_div_b     (div_b),
    .i_div_done  (div_done),
    .i_div_valid (div_valid),
    .i_div_dbz   (div_dbz),
    .i_div_ovf   (div_ovf),
    .i_div_val   (div_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Q4.4 signed division, truncating; magnitudes above 127 overflow.
  function automatic exp_t model_rsp(logic [7:0] a, logic [7:0] b, bit tmo);
    exp_t e;
    int   q;
    e = '0;
    e.tmo = tmo;
    if (!tmo) begin
      if (b == 8'h00) e.dbz = 1'b1;
      else begin
        q = (int'($signed(a)) * 16) / int'($signed(b));
        if (q > 127 || q < -127) e.ovf = 1'b1;
        else e.val = q[7:0];
      end
    end
    return e;
  endfunction

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  job_t q[$];
  int   grants[$];
  int   mptr = 0;
  bit   outstanding = 0, start_due = 0, post_rst = 0;
  bit   nodone = 0, spur_en = 0, prev_rspv = 0;
  int   fixlat = 0;
  int   cyc = 0, start_cyc = 0, rspv_cyc = 0, drst_cnt = 0;
  int   start_total = 0, accept_total = 0, rsp_cnt = 0;
  logic [N-1:0] acc_last = '0;
  int   last_id;
  logic [7:0] last_val;
  logic [2:0] last_flags;

  // Stub divider: samples at negedge, answers #1 after posedge.
  initial begin
    bit s, r, busy;
    int cnt;
    logic [7:0] ja, jb, sa, sb;
    exp_t e;
    busy = 0;
    cnt = 0;
    ja = '0;
    jb = '0;
    div_done = 0; div_valid = 0; div_dbz = 0; div_ovf = 0; div_val = '0;
    forever begin
      @(negedge clk);
      s = div_start; r = div_rst; sa = div_a; sb = div_b;
      @(posedge clk);
      #1;
      div_done = 1'b0;
      if (!rst_n || r) busy = 0;
      else if (s) begin
        busy = 1;
        cnt = (fixlat > 0) ? fixlat : int'($urandom_range(0, 10));
        ja = sa;
        jb = sb;
      end else if (busy) begin
        if (!nodone) begin
          if (cnt == 0) begin
            e = model_rsp(ja, jb, 1'b0);
            div_done  = 1'b1;
            div_dbz   = e.dbz;
            div_ovf   = e.ovf;
            div_valid = !(e.dbz || e.ovf);
            div_val   = div_valid ? e.val : 8'($urandom_range(1, 255));
            busy = 0;
          end else cnt--;
        end
      end else if (spur_en && $urandom_range(0, 5) == 0) begin
        div_done  = 1'b1;
        div_valid = 1'($urandom);
        div_dbz   = 1'($urandom);
        div_ovf   = 1'($urandom);
        div_val   = 8'($urandom);
      end
    end
  end

  // Monitor / compare process.
  initial begin
    exp_t e;
    int g, idx;
    logic [N-1:0] expg;
    job_t j;
    forever begin
      @(negedge clk);
      cyc++;
      acc_last = '0;
      if (rst_n) begin
        if (div_rst) drst_cnt++;
        if (div_start) start_total++;
        if (start_due) begin
          chk("start_pulse", div_start, 1);
          if (q.size() > 0) begin
            chk("div_a", div_a, q[0].a);
            chk("div_b", div_b, q[0].b);
          end
          start_due = 0;
          start_cyc = cyc;
        end else chk("no_extra_start", div_start, 0);
        if (bus.o_rsp_valid && !prev_rspv) rspv_cyc = cyc;
        if (outstanding) begin
          chk("ready_busy", bus.o_req_ready, 0);
          if (bus.o_rsp_valid && q.size() > 0) begin
            e = model_rsp(q[0].a, q[0].b, q[0].tmo);
            chk("rsp_id", bus.o_rsp_id, q[0].id);
            chk("rsp_val", bus.o_rsp_val, e.val);
            chk("rsp_dbz", bus.o_rsp_dbz, e.dbz);
            chk("rsp_ovf", bus.o_rsp_ovf, e.ovf);
            chk("rsp_tmo", bus.o_rsp_tmo, e.tmo);
            if (rsp_ready) begin
              last_id = int'(bus.o_rsp_id);
              last_val = bus.o_rsp_val;
              last_flags = {bus.o_rsp_dbz, bus.o_rsp_ovf, bus.o_rsp_tmo};
              void'(q.pop_front());
              outstanding = 0;
              rsp_cnt++;
            end
          end
        end else begin
          chk("rsp_idle", bus.o_rsp_valid, 0);
          if (post_rst) begin
            chk("ready_post_rst", bus.o_req_ready, 0);
            post_rst = 0;
          end else begin
            g = rr_pick(rvalid, mptr);
            expg = '0;
            if (g >= 0) expg[g] = 1'b1;
            chk("grant", bus.o_req_ready, expg);
          end
          acc_last = rvalid & bus.o_req_ready;
          if (|acc_last) begin
            idx = 0;
            for (int k = N - 1; k >= 0; k--) if (acc_last[k]) idx = k;
            j.id = idx; j.a = ra[idx]; j.b = rb[idx]; j.tmo = nodone;
            q.push_back(j);
            grants.push_back(idx);
            mptr = (idx + 1) % N;
            outstanding = 1;
            start_due = 1;
            accept_total++;
          end
        end
      end
      prev_rspv = rst_n && bus.o_rsp_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_ops(int k);
    ra[k] = 8'($urandom);
    rb[k] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
  endtask

  task automatic do_reset(int hold);
    rst_n = 1'b0;
    #1;
    chk("rst_ready", bus.o_req_ready, 0);
    chk("rst_rsp_valid", bus.o_rsp_valid, 0);
    chk("rst_rsp_payload", {bus.o_rsp_id, bus.o_rsp_val, bus.o_rsp_dbz,
                            bus.o_rsp_ovf, bus.o_rsp_tmo}, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_rst", div_rst, 1);
    chk("rst_div_ops", {div_a, div_b}, 0);
    q.delete();
    outstanding = 0;
    start_due = 0;
    mptr = 0;
    rvalid = '0;
    repeat (hold) step();
    rst_n = 1'b1;
    post_rst = 1;
  endtask

  task automatic do_job(int k, logic [7:0] a, logic [7:0] b);
    int n0, t;
    n0 = rsp_cnt;
    t = 0;
    ra[k] = a;
    rb[k] = b;
    rvalid[k] = 1'b1;
    rsp_ready = 1'b1;
    while (rsp_cnt == n0 && t < 300) begin
      step();
      if (acc_last[k]) rvalid[k] = 1'b0;
      t++;
    end
    chk("job_done_in_time", 32'(rsp_cnt - n0), 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    rvalid = '0;
    rsp_ready = 1'b1;
    while ((outstanding || start_due) && t < 300) begin
      step();
      t++;
    end
    chk("drain_idle", 32'(outstanding), 0);
  endtask

  initial begin
    int s0, t;
    int rr_exp[6];
    rr_exp = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0;
    rvalid = '0;
    ra = '0;
    rb = '0;
    rsp_ready = 1'b0;
    step();
    do_reset(3);

    // Request present while the divider is still held in reset.
    ra[0] = 8'h20; rb[0] = 8'h10; rvalid[0] = 1'b1;
    do_job(0, 8'h20, 8'h10);
    chk("j1_id", last_id, 0);
    chk("j1_val", last_val, 8'h20);
    chk("j1_flags", last_flags, 3'b000);
    do_job(0, 8'h30, 8'hE0);
    chk("j2_val", last_val, 8'hE8);
    chk("j2_flags", last_flags, 3'b000);
    do_job(2, 8'h40, 8'h00);
    chk("dbz_id", last_id, 2);
    chk("dbz_val", last_val, 8'h00);
    chk("dbz_flags", last_flags, 3'b100);
    do_job(1, 8'h80, 8'h10);
    chk("ovf_id", last_id, 1);
    chk("ovf_val", last_val, 8'h00);
    chk("ovf_flags", last_flags, 3'b010);

    // Round robin with all requesters permanently valid.
    step();
    do_reset(2);
    for (int k = 0; k < N; k++) new_ops(k);
    rvalid = '1;
    rsp_ready = 1'b1;
    grants.delete();
    t = 0;
    while (grants.size() < 6 && t < 500) begin
      step();
      for (int k = 0; k < N; k++) if (acc_last[k]) new_ops(k);
      t++;
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i),
          (i < grants.size()) ? grants[i] : -1, rr_exp[i]);
    drain();

    // Response backpressure with another req1 pending.
    rsp_ready = 1'b0;
    new_ops(1);
    rvalid[1] = 1'b1;
    t = 0;
    while (!bus.o_rsp_valid && t < 100) begin
      step();
      if (acc_last[1]) new_ops(1);
      t++;
    end
    s0 = start_total;
    repeat (20) begin
      step();
      if (acc_last[1]) new_ops(1);
    end
    chk("bp_no_start", 32'(start_total - s0), 0);
    chk("bp_rsp_held", bus.o_rsp_valid, 1);
    chk("bp_ready_low", bus.o_req_ready, 0);
    rsp_ready = 1'b1;
    t = 0;
    while (rvalid[1] && t < 100) begin
      step();
      if (acc_last[1]) rvalid[1] = 1'b0;
      t++;
    end
    drain();

    // Divider that never finishes.
    nodone = 1;
    drst_cnt = 0;
    do_job(3, 8'h10, 8'h10);
    nodone = 0;
    chk("tmo_id", last_id, 3);
    chk("tmo_val", last_val, 8'h00);
    chk("tmo_flags", last_flags, 3'b001);
    chk("tmo_latency", 32'((rspv_cyc - start_cyc) >= TO + 1 &&
                           (rspv_cyc - start_cyc) <= TO + 2), 1);
    chk("tmo_div_rst_pulse", drst_cnt, 1);
    do_job(0, 8'h18, 8'h08);
    chk("post_tmo_val", last_val, 8'h30);
    chk("post_tmo_flags", last_flags, 3'b000);

    // Reset while the divider is working.
    fixlat = 30;
    s0 = start_total;
    ra[2] = 8'h20; rb[2] = 8'h10; rvalid[2] = 1'b1;
    rsp_ready = 1'b1;
    t = 0;
    while (start_total == s0 && t < 50) begin
      step();
      if (acc_last[2]) rvalid[2] = 1'b0;
      t++;
    end
    chk("midrst_started", 32'(start_total - s0), 1);
    repeat (3) step();
    do_reset(2);
    fixlat = 0;
    s0 = rsp_cnt;
    repeat (40) step();
    chk("midrst_no_stale", 32'(rsp_cnt - s0), 0);
    do_job(1, 8'h30, 8'hE0);
    chk("post_rst_id", last_id, 1);
    chk("post_rst_val", last_val, 8'hE8);

    // Random traffic with spurious done pulses.
    spur_en = 1;
    for (int c = 0; c < 1500; c++) begin
      step();
      for (int k = 0; k < N; k++) begin
        if (acc_last[k]) begin
          rvalid[k] = 1'($urandom);
          if (rvalid[k]) new_ops(k);
        end else if (rvalid[k]) begin
          if ($urandom_range(0, 15) == 0) rvalid[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          rvalid[k] = 1'b1;
          new_ops(k);
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    drain();
    spur_en = 0;
    step();
    chk("starts_eq_accepts", start_total, accept_total);
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
